// File: rtl/add_sub_seq.sv
// add_sub_seq: multi-cycle chunked two's-complement adder/subtractor with flags; ADD_SUB_SEQ_SAT_EN enables signed saturation
module add_sub_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_c,
  output logic             out_overflow,
  output logic             out_zero
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_r, b_r, sum_r, sum_n, res;
  logic [CHUNK:0] chunk;
  logic [CW-1:0] cnt;
  logic carry, ovf;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  // add the current chunk and form the full result as it will look once this chunk lands
  always_comb begin
    chunk = {1'b0, a_r[cnt*CHUNK +: CHUNK]} + {1'b0, b_r[cnt*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, carry};
    sum_n = sum_r;
    sum_n[cnt*CHUNK +: CHUNK] = chunk[CHUNK-1:0];
    ovf = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_n[WIDTH-1] != a_r[WIDTH-1]);
`ifdef ADD_SUB_SEQ_SAT_EN
    res = ovf ? (a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : sum_n;
`else
    res = sum_n;
`endif
  end
  // handshake FSM; result and flags register only on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      out <= '0;
      out_c <= 1'b0;
      out_overflow <= 1'b0;
      out_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r <= a;
          b_r <= sub ? ~b : b;
          carry <= sub;
          cnt <= '0;
          state <= BUSY;
        end
        BUSY: begin
          sum_r <= sum_n;
          carry <= chunk[CHUNK];
          if (cnt == CW'(NCHUNK - 1)) begin
            out <= res;
            out_c <= chunk[CHUNK];
            out_overflow <= ovf;
            out_zero <= res == '0;
            state <= DONE;
          end else cnt <= cnt + 1'b1;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/add_sub_seq.md
Name: add_sub_seq

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor.
- Processes WIDTH-bit operands CHUNK bits per clock, carrying between chunks.
- Reports carry, signed overflow and zero flags alongside the result.
- Sits in the datapath experiments as the successor to the single-cycle 8-bit adder.
- Uses valid/ready handshakes on both sides so it can be dropped between a register file and a result latch.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 2.
- CHUNK, 4, bits processed per cycle; WIDTH % CHUNK must be 0. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operands and op valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0: a+b; 1: a-b.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer takes result.
- out  output  WIDTH  result.
- out_c  output  1  carry out of MSB (sub: 1 = no borrow, i.e. a >= b unsigned).
- out_overflow  output  1  signed overflow.
- out_zero  output  1  out == 0.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; chunk counter=0.
  - Outputs after reset: in_ready=1, out_valid=0, out=0, out_c=0, out_overflow=0, out_zero=0.
  - Reset overrides every other event and aborts any operation in progress; no result is produced for it.
- States:
  - IDLE: in_ready=1. On in_valid && in_ready:
    - latch a, b_eff = sub ? ~b : b, and sub;
    - set carry register = sub; cnt=0; go to BUSY.
  - BUSY: in_ready=0, out_valid=0. Each cycle add chunk cnt: a[cnt*CHUNK +: CHUNK] + b_eff[same] + carry.
    - Write the sum into the result register slice; carry register takes that chunk's carry out.
    - If cnt==NCHUNK-1, go to DONE; otherwise cnt++.
  - DONE: out_valid=1, outputs stable. On out_ready: go to IDLE, out_valid deasserts next cycle. Otherwise hold indefinitely.
- Latency: out_valid rises exactly NCHUNK cycles after the accepting edge.
  - Minimum initiation interval is NCHUNK+2 cycles.
  - in_ready is low in BUSY and DONE; no overlap of operations.
- Inputs a, b and sub are sampled only at the accepting edge; changes afterwards have no effect.
- Flags are computed on entry to DONE and registered:
  - out_c = final carry register.
  - out_overflow = (a[WIDTH-1]==b_eff[WIDTH-1]) && (out[WIDTH-1]!=a[WIDTH-1]).
  - out_zero = (out==0).
- Result equals (a + b_eff + sub) mod 2^WIDTH, identical to a single-cycle adder.
- Operands are treated as raw bits. Interpretation as signed or unsigned is the consumer's choice.
- out, out_c, out_overflow and out_zero hold their last values in IDLE and BUSY.
  - They update only on entry to DONE.
- in_valid while busy is ignored: no queuing, and the producer must hold until in_ready.
- NCHUNK==1 (CHUNK==WIDTH) is legal and gives latency 1.

Optional Feature:
- Macro: ADD_SUB_SEQ_SAT_EN.
- Defined: when out_overflow would be 1, out saturates to the signed extreme.
  - Positive overflow (a[WIDTH-1]==0) gives 0111..1; negative overflow gives 1000..0.
  - out_overflow still reports 1. out_c and out_zero are computed from the saturated value (out_c unchanged, from the raw carry).
- Not defined: out is the wrapped result; no saturation logic is present.

Test Plan (WIDTH=8, CHUNK=4):
- Reset, then a=0x7F b=0x01 sub=0 -> out_valid 2 cycles after accept; out=0x80, c=0, overflow=1, zero=0 (SAT_EN: out=0x7F).
- a=0xFF b=0x01 sub=0 -> out=0x00, c=1, overflow=0, zero=1.
- a=0x05 b=0x07 sub=1 -> out=0xFE, c=0, overflow=0, zero=0. Then a=0x80 b=0x01 sub=1 -> out=0x7F, c=1, overflow=1 (SAT_EN: out=0x80).
- Backpressure: out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset in BUSY (cycle after accept) -> next cycle in IDLE, out_valid=0, all outputs 0; a new op afterwards gives a correct result.
- Random 1000 ops, random out_ready stalls, CHUNK in {1,2,4,8} -> out/flags match a reference model.
